output_port_arbiter: RTL
========================

Name: output_port_arbiter

Overview:
- Shares one router output link among NUM_INPUTS input port controllers that route to it.
- Uses round-robin arbitration, one packet at a time. A winner holds the link until all FLIT_NUMBER flits of its packet have been transferred.
- Drives per-input stall back to each port controller and muxes the granted input's flit stream onto the output link.
- One instance sits per output port, between the input port controllers and the output link register.

Parameters:
- NUM_INPUTS, 5, number of input port controllers competing for this output.
- FLIT_SIZE, 4, flit width in bits.
- PACKET_SIZE, 32, packet width in bits. FLIT_NUMBER = PACKET_SIZE/FLIT_SIZE (8). This covers address plus payload flits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_INPUTS  input i requests this output. Held by the controller from routing decision until its last flit is sent.
- flit_in  in  NUM_INPUTS*FLIT_SIZE  flit from input i, occupying bits [i*FLIT_SIZE +: FLIT_SIZE].
- flit_valid  in  NUM_INPUTS  flit_in slice i is valid this cycle.
- out_ready  in  1  downstream accepts a flit this cycle.
- grant  out  NUM_INPUTS  one-hot registered grant; all zero when idle.
- stall  out  NUM_INPUTS  combinational, equal to req & ~grant.
- flit_out  out  FLIT_SIZE  flit_in slice of the granted input; zero when idle.
- flit_out_valid  out  1  equal to flit_valid[g] while granted; 0 when idle.
- packet_done  out  1  one-cycle pulse on the cycle the last flit transfers.
- protocol_err  out  1  sticky; set when the granted input drops req before its packet completes.

Behaviour:
- Reset:
  - state=IDLE; grant=0; rr_ptr=0; flit_cnt=0; packet_done=0; protocol_err=0.
  - Outputs derived from these: flit_out=0, flit_out_valid=0, stall=req.
  - Reset wins over every other event, including mid-packet. The partial packet is abandoned.
- Transfer definition: a transfer occurs when state=LOCKED, flit_out_valid=1 and out_ready=1.
- State IDLE:
  - If req is non-zero, pick the first set req bit searching upward from rr_ptr, wrapping modulo NUM_INPUTS.
  - On the next edge: grant <= onehot(winner), flit_cnt <= 0, state <= LOCKED.
  - Grant latency is 1 cycle from req rising.
  - If req is zero, stay in IDLE.
- State LOCKED:
  - grant is frozen. Other requesters see stall=1.
  - flit_cnt increments on each transfer. With out_ready=0 or flit_valid[g]=0, flit_cnt holds and no flit is lost.
  - On a transfer with flit_cnt==FLIT_NUMBER-1:
    - packet_done=1 that cycle.
    - Next edge: grant <= 0, rr_ptr <= (g+1) mod NUM_INPUTS (wrapping at NUM_INPUTS-1 -> 0), flit_cnt <= 0, state <= IDLE.
  - The IDLE cycle that follows is a mandatory one-cycle turnaround. It lets the finished controller drop req before re-arbitration.
  - Minimum spacing between packets from different inputs is FLIT_NUMBER+1 cycles.
- Width rules: flit_cnt is $clog2(FLIT_NUMBER) bits wide. rr_ptr is $clog2(NUM_INPUTS) bits wide. rr_ptr increments by explicit compare-and-wrap, not natural overflow.
- Simultaneous requests: only one input is granted. The rest see stall=1 until they win.
- Same input re-requests immediately after its packet: it is served only after every other pending requester, because rr_ptr has passed it.
- Granted req drops mid-packet:
  - protocol_err <= 1 (sticky until reset).
  - The grant is still held until FLIT_NUMBER transfers complete. The output link is never released mid-packet.
- flit_valid on non-granted inputs is ignored.
- req changes on non-granted inputs during LOCKED affect only stall.

Decomposition:
- Shared package noc_pkg:
  - FLIT_SIZE, PACKET_SIZE, ADDRESS_SIZE, FLIT_NUMBER.
  - Port index constants (LOCAL, NORTH, EAST, SOUTH, WEST = 0..4).
  - The state enum {IDLE, LOCKED}.
- Sub-module rr_pick: purely combinational. Inputs are req and rr_ptr; outputs are the one-hot winner and winner index. It is reused by other output ports.

Test Plan:
- Single requester: reset, req=5'b00100, flit_valid[2]=1, out_ready=1.
  - grant=5'b00100 one cycle after req.
  - 8 flits appear on flit_out in order.
  - packet_done pulses on the 8th flit.
  - grant=0 next cycle; rr_ptr=3.
- Contention: req=5'b10011 constant, all valid, out_ready=1.
  - Grants in order 00001, 00010, 10000, 00001.
  - Each grant holds exactly 8 transfers, separated by one idle cycle.
  - stall equals req & ~grant throughout.
- Backpressure: out_ready toggled 1,0,0,1,... during a packet.
  - flit_cnt advances only on out_ready=1 cycles.
  - packet_done occurs only after the 8th accepted flit; no flit is duplicated or dropped.
- Wrap-around: last grant was input 4 (rr_ptr wraps to 0), then req=5'b10001.
  - Input 0 is granted before input 4.
- Protocol error: the granted input drops req after 3 flits.
  - protocol_err=1 and stays set.
  - grant holds until 8 transfers complete.
- Reset mid-packet: assert reset after 4 flits.
  - Next cycle: grant=0, flit_out_valid=0, protocol_err=0, state IDLE.
  - With req still set, a new grant appears 1 cycle after reset deasserts, starting from input 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit/packet geometry, router port indices and the
// output-arbiter state encoding used by every output port instance.
package noc_pkg;

  localparam int FLIT_SIZE    = 4;
  localparam int PACKET_SIZE  = 32;
  localparam int ADDRESS_SIZE = 8;
  localparam int FLIT_NUMBER  = PACKET_SIZE / FLIT_SIZE;

  // Router port indices; also the input numbering seen by each output arbiter.
  localparam int NUM_PORTS = 5;
  localparam int LOCAL     = 0;
  localparam int NORTH     = 1;
  localparam int EAST      = 2;
  localparam int SOUTH     = 3;
  localparam int WEST      = 4;

  // IDLE: link free, arbitrating. LOCKED: link owned by one input for a packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first asserted request at or above
// rr_ptr_i, wrapping modulo N. Purely combinational, shared by all output
// ports of the router.
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  winner_oh_o,
  output logic [IW-1:0] winner_idx_o,
  output logic          any_o
);

  int   cand;
  logic found;

  // Scan N candidate positions starting at the pointer; the first hit wins.
  always_comb begin
    winner_oh_o  = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    cand         = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req_i[cand]) begin
        found             = 1'b1;
        winner_idx_o      = cand[IW-1:0];
        winner_oh_o[cand] = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port arbiter: shares one router output link among NUM_INPUTS input
// port controllers. Round-robin, packet-granular: a winner keeps the link
// until all of its flits have been transferred, then the link idles one
// cycle so the finished controller can drop req before re-arbitration.
//
// Handshake: a flit transfers on a cycle where the link is LOCKED,
// flit_out_valid (the granted input's flit_valid) is 1 and out_ready is 1.
// Either side may stall; the flit and the flit counter simply hold.
module output_port_arbiter #(
  parameter int NUM_INPUTS  = noc_pkg::NUM_PORTS,
  parameter int FLIT_SIZE   = noc_pkg::FLIT_SIZE,
  parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUTS-1:0]           req,
  input  logic [NUM_INPUTS*FLIT_SIZE-1:0] flit_in,
  input  logic [NUM_INPUTS-1:0]           flit_valid,
  input  logic                            out_ready,
  output logic [NUM_INPUTS-1:0]           grant,
  output logic [NUM_INPUTS-1:0]           stall,
  output logic [FLIT_SIZE-1:0]            flit_out,
  output logic                            flit_out_valid,
  output logic                            packet_done,
  output logic                            protocol_err,
  output noc_pkg::arb_state_e             state_dbg
);

  import noc_pkg::*;

  localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
  localparam int CW    = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [CW-1:0] LAST_FLIT = CW'(FLITS - 1);
  localparam logic [IW-1:0] LAST_IN   = IW'(NUM_INPUTS - 1);

  arb_state_e            state_q, state_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         flit_cnt_q, flit_cnt_d;
  logic                  perr_q, perr_d;

  logic [NUM_INPUTS-1:0] pick_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  logic locked;
  logic xfer;
  logic last_xfer;

  rr_pick #(
    .N  (NUM_INPUTS),
    .IW (IW)
  ) u_pick (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx),
    .any_o        (pick_any)
  );

  // Datapath: mux the granted input onto the link and flag transfers.
  always_comb begin
    locked         = (state_q == LOCKED);
    flit_out_valid = locked & flit_valid[gidx_q];
    flit_out       = locked ? flit_in[int'(gidx_q)*FLIT_SIZE +: FLIT_SIZE] : '0;
    xfer           = flit_out_valid & out_ready;
    last_xfer      = xfer && (flit_cnt_q == LAST_FLIT);
    packet_done    = last_xfer;
    stall          = req & ~grant_q;
    grant          = grant_q;
    protocol_err   = perr_q;
    state_dbg      = state_q;
  end

  // Next-state: arbitrate in IDLE, count flits and release in LOCKED.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    flit_cnt_d = flit_cnt_q;
    perr_d     = perr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_oh;
          gidx_d     = pick_idx;
          flit_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        // The owner must hold req until its last flit; the link is kept
        // regardless so downstream never sees a truncated packet.
        if (!req[gidx_q]) begin
          perr_d = 1'b1;
        end
        if (last_xfer) begin
          grant_d    = '0;
          flit_cnt_d = '0;
          rr_ptr_d   = (gidx_q == LAST_IN) ? '0 : gidx_q + 1'b1;
          state_d    = IDLE;
        end else if (xfer) begin
          flit_cnt_d = flit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      flit_cnt_q <= flit_cnt_d;
      perr_q     <= perr_d;
    end
  end

endmodule
